// File: rtl/layer_compositor.sv
`default_nettype none
// ============================================================================
//  Module      : layer_compositor
//  Description : Two-stage pipelined priority compositor. Merges NUM_LAYERS
//                renderer layers plus a background colour into one RGB
//                stream. Adds frame-synchronous layer enables, per-layer
//                blinking and a per-frame overlap (collision) flag. Sync and
//                display-enable are delayed to stay aligned with colour.
//  Revision    : 1.0 - initial release
// ============================================================================
module layer_compositor #(
    parameter int NUM_LAYERS   = 4,
    parameter int COLOR_W      = 8,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            display_area,
    input  logic                            hsync_in,
    input  logic                            vsync_in,
    input  logic [NUM_LAYERS-1:0]           layer_draw,
    input  logic [NUM_LAYERS*3*COLOR_W-1:0] layer_rgb,
    input  logic [3*COLOR_W-1:0]            bg_rgb,
    input  logic [NUM_LAYERS-1:0]           layer_enable,
    input  logic [NUM_LAYERS-1:0]           blink_mask,
    output logic [COLOR_W-1:0]              r,
    output logic [COLOR_W-1:0]              g,
    output logic [COLOR_W-1:0]              b,
    output logic                            hsync,
    output logic                            vsync,
    output logic                            de_out,
    output logic                            overlap
);

    localparam int PIX_W = 3 * COLOR_W;
    localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_FRAMES - 1);

    // Stage-1 pixel source codes
    localparam logic [1:0] SEL_BLANK = 2'd0;
    localparam logic [1:0] SEL_BG    = 2'd1;
    localparam logic [1:0] SEL_LAYER = 2'd2;

    // Frame-level control state
    logic [NUM_LAYERS-1:0]           r_enable_q;
    logic [NUM_LAYERS-1:0]           r_blink_q;
    logic [CNT_W-1:0]                r_frame_cnt;
    logic                            r_blink_phase;
    logic                            r_overlap_acc;

    // Stage-1 registers
    logic [1:0]                      r_sel_s1;
    logic [IDX_W-1:0]                r_idx_s1;
    logic                            r_de_s1;
    logic                            r_hs_s1;
    logic                            r_vs_s1;
    logic [NUM_LAYERS*PIX_W-1:0]     r_layer_rgb_s1;
    logic [PIX_W-1:0]                r_bg_rgb_s1;

    // Stage-2 colour register
    logic [PIX_W-1:0]                r_rgb_s2;

    // Combinational helpers
    logic                            w_fb;
    logic [NUM_LAYERS-1:0]           w_visible;
    logic                            w_any;
    logic                            w_multi;
    logic [IDX_W-1:0]                w_idx;
    logic [1:0]                      w_sel;
    logic [PIX_W-1:0]                w_color;

    // The stage-1 vsync copy doubles as the "previous vsync" for edge detect
    assign w_fb = r_vs_s1 & ~vsync_in;

    // Visibility: drawing, enabled by the shadow mask, and not blanked by blink
    always_comb begin
        w_visible = layer_draw & r_enable_q & ~(r_blink_q & {NUM_LAYERS{r_blink_phase}});
        w_any     = |w_visible;
        // Clearing the lowest set bit leaves something only if two or more are set
        w_multi   = |(w_visible & (w_visible - NUM_LAYERS'(1)));
    end

    // Priority encoder: lowest-index visible layer wins
    always_comb begin
        w_idx = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (w_visible[i]) begin
                w_idx = IDX_W'(i);
            end
        end
    end

    // Pixel source decision for stage 1
    always_comb begin
        w_sel = SEL_BLANK;
        if (display_area) begin
            w_sel = w_any ? SEL_LAYER : SEL_BG;
        end
    end

    // Frame-boundary shadow registers, blink timing and overlap tracking
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_enable_q    <= '1;
            r_blink_q     <= '0;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_overlap_acc <= 1'b0;
            overlap       <= 1'b0;
        end else if (w_fb) begin
            r_enable_q    <= layer_enable;
            r_blink_q     <= blink_mask;
            if (r_frame_cnt == CNT_MAX) begin
                r_frame_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_frame_cnt   <= r_frame_cnt + CNT_W'(1);
            end
            // Any coincidence in the boundary cycle itself is discarded
            overlap       <= r_overlap_acc;
            r_overlap_acc <= 1'b0;
        end else if (display_area && w_multi) begin
            r_overlap_acc <= 1'b1;
        end
    end

    // Stage 1: register selection, timing signals and a copy of the colours
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sel_s1       <= SEL_BLANK;
            r_idx_s1       <= '0;
            r_de_s1        <= 1'b0;
            r_hs_s1        <= 1'b1;
            r_vs_s1        <= 1'b1;
            r_layer_rgb_s1 <= '0;
            r_bg_rgb_s1    <= '0;
        end else begin
            r_sel_s1       <= w_sel;
            r_idx_s1       <= w_idx;
            r_de_s1        <= display_area;
            r_hs_s1        <= hsync_in;
            r_vs_s1        <= vsync_in;
            r_layer_rgb_s1 <= layer_rgb;
            r_bg_rgb_s1    <= bg_rgb;
        end
    end

    // Stage-2 colour mux from the stage-1 colour copies
    always_comb begin
        w_color = '0;
        case (r_sel_s1)
            SEL_BG: begin
                w_color = r_bg_rgb_s1;
            end
            SEL_LAYER: begin
                for (int i = 0; i < NUM_LAYERS; i++) begin
                    if (r_idx_s1 == IDX_W'(i)) begin
                        w_color = r_layer_rgb_s1[i*PIX_W +: PIX_W];
                    end
                end
            end
            default: begin
                w_color = '0;
            end
        endcase
    end

    // Stage 2: output registers, syncs kept aligned with colour
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rgb_s2 <= '0;
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            de_out   <= 1'b0;
        end else begin
            r_rgb_s2 <= w_color;
            hsync    <= r_hs_s1;
            vsync    <= r_vs_s1;
            de_out   <= r_de_s1;
        end
    end

    assign r = r_rgb_s2[3*COLOR_W-1 -: COLOR_W];
    assign g = r_rgb_s2[2*COLOR_W-1 -: COLOR_W];
    assign b = r_rgb_s2[COLOR_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_layer_compositor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_layer_compositor
//  Description : Self-checking bench for layer_compositor (4 layers, 8-bit
//                colour, 2-frame blink half-period). Expected pixels are
//                queued at drive time and compared two clocks later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_compositor;

    localparam int NL = 4;
    localparam int CW = 8;
    localparam int BF = 2;
    localparam int PW = 3 * CW;

    localparam logic [PW-1:0] C_L0 = 24'h112233;
    localparam logic [PW-1:0] C_L1 = 24'hFF0000;
    localparam logic [PW-1:0] C_L2 = 24'h00FF00;
    localparam logic [PW-1:0] C_L3 = 24'h0000FF;
    localparam logic [PW-1:0] C_BG = 24'h101010;

    logic              clk = 1'b0;
    logic              reset;
    logic              display_area;
    logic              hsync_in;
    logic              vsync_in;
    logic [NL-1:0]     layer_draw;
    logic [NL*PW-1:0]  layer_rgb;
    logic [PW-1:0]     bg_rgb;
    logic [NL-1:0]     layer_enable;
    logic [NL-1:0]     blink_mask;
    logic [CW-1:0]     r, g, b;
    logic              hsync, vsync, de_out, overlap;

    layer_compositor #(
        .NUM_LAYERS   (NL),
        .COLOR_W      (CW),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .display_area (display_area),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .layer_draw   (layer_draw),
        .layer_rgb    (layer_rgb),
        .bg_rgb       (bg_rgb),
        .layer_enable (layer_enable),
        .blink_mask   (blink_mask),
        .r            (r),
        .g            (g),
        .b            (b),
        .hsync        (hsync),
        .vsync        (vsync),
        .de_out       (de_out),
        .overlap      (overlap)
    );

    always #20 clk = ~clk;

    typedef struct packed {
        logic          chk;
        logic [PW-1:0] rgb;
        logic          hs;
        logic          vs;
        logic          de;
    } exp_t;

    typedef struct packed {
        logic          de;
        logic          hs;
        logic [NL-1:0] draw;
        logic [PW-1:0] rgb;
    } vec_t;

    exp_t  sb_q[$];
    int    tests = 0;
    int    fails = 0;
    int    px_no = 0;
    string cur_name = "init";

    task automatic check_px(input exp_t e);
        px_no++;
        if (e.chk) begin
            tests++;
            if ({r, g, b} !== e.rgb || hsync !== e.hs || vsync !== e.vs || de_out !== e.de) begin
                fails++;
                $display("FAIL %s px%0d: got rgb=%06h hs=%b vs=%b de=%b, expected rgb=%06h hs=%b vs=%b de=%b",
                         cur_name, px_no, {r, g, b}, hsync, vsync, de_out, e.rgb, e.hs, e.vs, e.de);
            end
        end
    endtask

    // One pixel per call: compare the pixel driven two clocks ago, then drive
    task automatic drive(input logic de, input logic hs, input logic vs,
                         input logic [NL-1:0] draw, input logic [PW-1:0] rgb, input logic chk);
        exp_t e;
        @(negedge clk);
        if (sb_q.size() >= 2) check_px(sb_q.pop_front());
        display_area = de;
        hsync_in     = hs;
        vsync_in     = vs;
        layer_draw   = draw;
        e.chk = chk;
        e.rgb = de ? rgb : '0;
        e.hs  = hs;
        e.vs  = vs;
        e.de  = de;
        sb_q.push_back(e);
    endtask

    task automatic vblank(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b1, 1'b0, '0, '0, 1'b1);
    endtask

    task automatic check_ovl(input logic exp, input string name);
        tests++;
        if (overlap !== exp) begin
            fails++;
            $display("FAIL %s: overlap=%b expected %b", name, overlap, exp);
        end
    endtask

    // One-cycle reset pulse with the outputs checked right after the edge
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        sb_q.delete();
        @(posedge clk);
        #1;
        tests++;
        if ({r, g, b} !== 24'h0 || hsync !== 1'b1 || vsync !== 1'b1 || de_out !== 1'b0 || overlap !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: got rgb=%06h hs=%b vs=%b de=%b ovl=%b, expected rgb=000000 hs=1 vs=1 de=0 ovl=0",
                     {r, g, b}, hsync, vsync, de_out, overlap);
        end
        @(negedge clk);
        reset        = 1'b1;
        display_area = 1'b0;
        hsync_in     = 1'b1;
        vsync_in     = 1'b1;
        layer_draw   = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t          vecs[10];
        logic [PW-1:0] v;

        reset        = 1'b0;
        display_area = 1'b0;
        hsync_in     = 1'b1;
        vsync_in     = 1'b1;
        layer_draw   = '0;
        layer_rgb    = {C_L3, C_L2, C_L1, C_L0};
        bg_rgb       = C_BG;
        layer_enable = '1;
        blink_mask   = '0;

        vecs[0] = '{1'b1, 1'b1, 4'b0110, C_L1};
        vecs[1] = '{1'b1, 1'b1, 4'b0000, C_BG};
        vecs[2] = '{1'b0, 1'b1, 4'b1111, 24'h0};
        vecs[3] = '{1'b1, 1'b0, 4'b1111, C_L0};
        vecs[4] = '{1'b1, 1'b0, 4'b1000, C_L3};
        vecs[5] = '{1'b1, 1'b1, 4'b1100, C_L2};
        vecs[6] = '{1'b1, 1'b0, 4'b0101, C_L0};
        vecs[7] = '{1'b1, 1'b1, 4'b0100, C_L2};
        vecs[8] = '{1'b1, 1'b0, 4'b1010, C_L1};
        vecs[9] = '{1'b0, 1'b0, 4'b0000, 24'h0};

        repeat (3) @(negedge clk);
        do_reset();

        // Priority / background / blanking table (frame 0)
        cur_name = "priority";
        for (int i = 0; i < 10; i++)
            drive(vecs[i].de, vecs[i].hs, 1'b1, vecs[i].draw, vecs[i].rgb, 1'b1);

        // Colour must come from the same cycle as the draw bits
        cur_name = "rgb_track";
        for (int i = 0; i < 8; i++) begin
            v = {8'(i * 17 + 3), 8'(250 - i * 9), 8'(i * 31)};
            drive(1'b1, 1'b1, 1'b1, 4'b0010, v, 1'b1);
            layer_rgb[PW +: PW] = v;
        end

        // Sync shape: 96-cycle hsync pulse followed by a display window
        cur_name = "sync_shape";
        for (int i = 0; i < 120; i++)
            drive((i >= 110), !(i >= 8 && i < 104), 1'b1, 4'b0000, C_BG, 1'b1);
        layer_rgb = {C_L3, C_L2, C_L1, C_L0};

        // FB1: overlap from frame 0 appears on the edge that samples FB
        cur_name = "fb1";
        check_ovl(1'b0, "ovl_frame0_hold");
        drive(1'b0, 1'b1, 1'b0, '0, '0, 1'b1);
        check_ovl(1'b0, "ovl_fb_cycle");
        drive(1'b0, 1'b1, 1'b0, '0, '0, 1'b1);
        check_ovl(1'b1, "ovl_after_fb1");
        drive(1'b0, 1'b1, 1'b0, '0, '0, 1'b1);

        // Frame 1: coincidences outside display area are ignored
        cur_name = "frame1";
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b1, 4'b0011, '0, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b1, 4'b0001, C_L0, 1'b1);
        check_ovl(1'b1, "ovl_frame1_hold");
        vblank(3);                                             // FB2
        check_ovl(1'b0, "ovl_gated_de");

        // Frame 2: single-pixel coincidence
        cur_name = "frame2";
        drive(1'b1, 1'b1, 1'b1, 4'b0011, C_L0, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 4'b0000, C_BG, 1'b1);
        check_ovl(1'b0, "ovl_frame2_hold");
        vblank(3);                                             // FB3
        check_ovl(1'b1, "ovl_single_px");

        // Frame 3: clean, but the FB cycle itself has a coincidence
        cur_name = "frame3";
        drive(1'b1, 1'b1, 1'b1, 4'b0100, C_L2, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 4'b0100, C_L2, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 4'b0011, C_L0, 1'b1);          // FB4
        vblank(2);
        check_ovl(1'b0, "ovl_clean_frame");
        drive(1'b1, 1'b1, 1'b1, 4'b0001, C_L0, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 4'b0001, C_L0, 1'b1);
        vblank(3);                                             // FB5
        check_ovl(1'b0, "ovl_fb_px_dropped");

        // Frame-synchronous enable: layer 0 disabled mid-frame
        cur_name = "enable";
        layer_enable = 4'b1110;
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b1, 4'b0001, C_L0, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 4'b0001, C_L0, 1'b1);          // FB6
        drive(1'b1, 1'b1, 1'b0, 4'b0001, C_BG, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 4'b0001, C_BG, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 4'b0001, C_BG, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 4'b0011, C_L1, 1'b1);
        layer_enable = 4'b1111;
        vblank(3);                                             // FB7
        drive(1'b1, 1'b1, 1'b1, 4'b0001, C_L0, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 4'b0001, C_L0, 1'b1);

        // Extra frames so the blink counter is mid-cycle before reset
        cur_name = "pre_reset";
        for (int f = 0; f < 3; f++) begin                      // FB8..FB10
            drive(1'b1, 1'b1, 1'b1, 4'b0001, C_L0, 1'b1);
            vblank(3);
        end
        drive(1'b1, 1'b1, 1'b1, 4'b0011, C_L0, 1'b1);
        layer_enable = 4'b0000;
        vblank(3);                                             // FB11
        check_ovl(1'b1, "ovl_before_reset");
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 4'b0011, C_BG, 1'b1);

        // Reset during active video
        do_reset();
        cur_name = "post_reset";
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 4'b0001, C_L0, 1'b1);
        check_ovl(1'b0, "ovl_after_reset");

        // Blink: layer 1 hidden in frames 2-3 only
        cur_name = "blink";
        layer_enable = 4'b1111;
        blink_mask   = 4'b0010;
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 4; i++)
                drive(1'b1, 1'b1, 1'b1, 4'b0010, (f == 2 || f == 3) ? C_BG : C_L1, 1'b1);
            drive(1'b1, 1'b1, 1'b1, 4'b0110, (f == 2 || f == 3) ? C_L2 : C_L1, 1'b1);
            if (f < 5) vblank(2);
        end

        cur_name = "flush";
        drive(1'b0, 1'b1, 1'b1, '0, '0, 1'b1);
        drive(1'b0, 1'b1, 1'b1, '0, '0, 1'b1);
        drive(1'b0, 1'b1, 1'b1, '0, '0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, '0, '0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
